chunked_seq_adder: RTL and testbench

Multi-cycle, parametrised adder that computes `WIDTH`-bit `a + b + cin` by processing `CHUNK` bits per clock, LSB chunk first, with a ripple carry held in a register between chunks. It generalises the 64-bit combinational `bit_Adder` into a handshaked unit for the RISC-V datapath. Area is traded for latency, and operands are accepted and results returned over valid/ready.

---
 rtl/chunked_seq_adder.sv | 150 +++++++++++++++
 tb/tb_chunked_seq_adder.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/chunked_seq_adder.sv
// Multi-cycle WIDTH-bit adder: CHUNK bits per clock, LSB first, valid/ready on both sides.
// Optional subtract mode (a - b - cin) is enabled by defining CHUNKED_ADDER_SUB_EN.
module chunked_seq_adder #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned CHUNK = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef CHUNKED_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int unsigned NCHUNK = WIDTH / CHUNK;
    localparam int unsigned IdxW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int unsigned CarryW = CHUNK + 1;
    localparam logic [IdxW-1:0]  LastIdx   = IdxW'(NCHUNK - 1);
    localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic [IdxW-1:0]  idx_q, idx_d;
    logic             carry_q, carry_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [WIDTH-1:0] b_eff;
    logic             cin_eff;
    logic [31:0]      lsb;
    logic [CHUNK-1:0] a_chunk;
    logic [CHUNK-1:0] b_chunk;
    logic [CHUNK:0]   chunk_sum;
    logic [CHUNK-1:0] chunk_res;
    logic             chunk_cout;
    logic             msb_cin;

    // Subtraction is a + ~b + ~cin; B is stored already inverted so RUN is add-only.
`ifdef CHUNKED_ADDER_SUB_EN
    always_comb begin
        b_eff   = sub ? ~b : b;
        cin_eff = cin ^ sub;
    end
`else
    always_comb begin
        b_eff   = b;
        cin_eff = cin;
    end
`endif

    always_comb begin
        lsb        = 32'(idx_q) * CHUNK;
        a_chunk    = CHUNK'(a_q >> lsb);
        b_chunk    = CHUNK'(b_q >> lsb);
        chunk_sum  = {1'b0, a_chunk} + {1'b0, b_chunk} + CarryW'(carry_q);
        chunk_res  = chunk_sum[CHUNK-1:0];
        chunk_cout = chunk_sum[CHUNK];
        // Carry into the MSB recovered from the MSB's own sum bit.
        msb_cin    = a_chunk[CHUNK-1] ^ b_chunk[CHUNK-1] ^ chunk_res[CHUNK-1];
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;

        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b_eff;
                    carry_d = cin_eff;
                    sum_d   = '0;
                    idx_d   = '0;
                    cout_d  = 1'b0;
                    ovf_d   = 1'b0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_d   = (sum_q & ~(ChunkMask << lsb)) | (WIDTH'(chunk_res) << lsb);
                carry_d = chunk_cout;
                idx_d   = idx_q + 1'b1;
                if (idx_q == LastIdx) begin
                    cout_d  = chunk_cout;
                    ovf_d   = chunk_cout ^ msb_cin;
                    idx_d   = '0;
                    state_d = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Self-checking bench for chunked_seq_adder: vector table plus reset/backpressure sequences.
// Subtract vectors are exercised when CHUNKED_ADDER_SUB_EN is defined.
module tb_chunked_seq_adder;
    localparam int unsigned WIDTH = 64;
    parameter  int unsigned CHUNK = 16;
    localparam int unsigned NCHUNK  = WIDTH / CHUNK;
    localparam int unsigned TIMEOUT = NCHUNK + 20;

    typedef struct {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             sub;
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
        int               hold;
        bit               toggle;
    } vec_t;

    typedef struct {
        logic [WIDTH-1:0] sum;
        logic             cout;
        logic             ovf;
    } exp_t;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
`ifdef CHUNKED_ADDER_SUB_EN
    logic             sub;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             cout;
    logic             ovf;

    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    vec_t vecs[$];

    chunked_seq_adder #(
        .WIDTH(WIDTH),
        .CHUNK(CHUNK)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
`ifdef CHUNKED_ADDER_SUB_EN
        .sub      (sub),
`endif
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_vec(input string name, input logic [WIDTH-1:0] act,
                             input logic [WIDTH-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %b, expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference: full-precision add; overflow from operand/result sign agreement.
    function automatic exp_t model(input logic [WIDTH-1:0] op_a, input logic [WIDTH-1:0] op_b,
                                   input logic c, input logic s);
        exp_t             r;
        logic [WIDTH:0]   full;
        logic [WIDTH-1:0] bb;
        logic             ci;
        bb     = s ? ~op_b : op_b;
        ci     = c ^ s;
        full   = {1'b0, op_a} + {1'b0, bb} + {{WIDTH{1'b0}}, ci};
        r.sum  = full[WIDTH-1:0];
        r.cout = full[WIDTH];
        r.ovf  = (op_a[WIDTH-1] == bb[WIDTH-1]) && (full[WIDTH-1] != op_a[WIDTH-1]);
        return r;
    endfunction

    function automatic vec_t mk(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                                input logic vc, input logic vs, input logic [WIDTH-1:0] es,
                                input logic ec, input logic eo, input int h, input bit t);
        vec_t v;
        v.a = va; v.b = vb; v.cin = vc; v.sub = vs;
        v.sum = es; v.cout = ec; v.ovf = eo; v.hold = h; v.toggle = t;
        return v;
    endfunction

    task automatic drive_ops(input logic [WIDTH-1:0] va, input logic [WIDTH-1:0] vb,
                             input logic vc, input logic vs);
        a   = va;
        b   = vb;
        cin = vc;
`ifdef CHUNKED_ADDER_SUB_EN
        sub = vs;
`else
        if (vs) $display("note: subtract vector skipped in add-only build");
`endif
    endtask

    task automatic wait_ready(input string tag);
        int n;
        n = 0;
        while (!in_ready && n < TIMEOUT) begin
            tick();
            n++;
        end
        if (!in_ready) check_bit({tag, " in_ready_wait"}, in_ready, 1'b1);
    endtask

    task automatic run_op(input vec_t v, input string tag);
        int   lat;
        exp_t e;
        exp_t exp_hold;
        wait_ready(tag);
        drive_ops(v.a, v.b, v.cin, v.sub);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        exp_hold.sum = v.sum; exp_hold.cout = v.cout; exp_hold.ovf = v.ovf;
        sb.push_back(exp_hold);
        lat = 0;
        while (!out_valid && lat < TIMEOUT) begin
            check_bit({tag, " in_ready_busy"}, in_ready, 1'b0);
            if (v.toggle) begin
                a        = {$urandom(), $urandom()};
                b        = {$urandom(), $urandom()};
                in_valid = 1'(($urandom() >> 3) & 1);
            end
            tick();
            lat++;
        end
        in_valid = 1'b0;
        if (!out_valid) begin
            check_bit({tag, " out_valid_timeout"}, out_valid, 1'b1);
            void'(sb.pop_front());
            return;
        end
        check_int({tag, " latency"}, lat, NCHUNK);
        check_bit({tag, " in_ready_in_done"}, in_ready, 1'b0);
        for (int i = 0; i < v.hold; i++) begin
            tick();
            check_bit({tag, " hold_valid"}, out_valid, 1'b1);
            check_vec({tag, " hold_sum"}, sum, exp_hold.sum);
            check_bit({tag, " hold_cout"}, cout, exp_hold.cout);
        end
        e = sb.pop_front();
        check_vec({tag, " sum"}, sum, e.sum);
        check_bit({tag, " cout"}, cout, e.cout);
        check_bit({tag, " ovf"}, ovf, e.ovf);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check_bit({tag, " in_ready_after"}, in_ready, 1'b1);
        check_bit({tag, " out_valid_after"}, out_valid, 1'b0);
    endtask

    task automatic check_reset_state(input string tag);
        check_bit({tag, " in_ready"}, in_ready, 1'b1);
        check_bit({tag, " out_valid"}, out_valid, 1'b0);
        check_vec({tag, " sum"}, sum, '0);
        check_bit({tag, " cout"}, cout, 1'b0);
        check_bit({tag, " ovf"}, ovf, 1'b0);
    endtask

    initial begin
        logic             seen;
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        logic             rc;
        exp_t             m;

        n_checks  = 0;
        n_errors  = 0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        drive_ops('0, '0, 1'b0, 1'b0);

        vecs.push_back(mk(64'd5, 64'hA, 1'b0, 1'b0, 64'hF, 1'b0, 1'b0, 0, 1'b0));
        vecs.push_back(mk(64'hFF, 64'd1, 1'b1, 1'b0, 64'h101, 1'b0, 1'b0, 0, 1'b0));
        vecs.push_back(mk('1, 64'd1, 1'b0, 1'b0, 64'd0, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk('1, '1, 1'b1, 1'b0, '1, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
                          64'h8000_0000_0000_0000, 1'b0, 1'b1, 0, 1'b0));
        vecs.push_back(mk(64'h1234_5678_90AB_CDEF, 64'hFEDC_BA09_8765_4321, 1'b0, 1'b0,
                          64'h1111_1082_1811_1110, 1'b1, 1'b0, 5, 1'b1));
        vecs.push_back(mk(64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b0, 1'b0,
                          64'd0, 1'b1, 1'b1, 0, 1'b0));
`ifdef CHUNKED_ADDER_SUB_EN
        vecs.push_back(mk(64'd10, 64'd3, 1'b0, 1'b1, 64'd7, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk(64'd3, 64'd10, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 1'b0, 1'b0, 0, 1'b0));
        vecs.push_back(mk(64'd10, 64'd3, 1'b1, 1'b1, 64'd6, 1'b1, 1'b0, 0, 1'b0));
        vecs.push_back(mk(64'h8000_0000_0000_0000, 64'd1, 1'b0, 1'b1,
                          64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1'b1, 0, 1'b0));
        vecs.push_back(mk(64'd10, 64'd3, 1'b0, 1'b0, 64'd13, 1'b0, 1'b0, 0, 1'b0));
`endif

        tick();
        tick();
        check_reset_state("reset_held");
        rst_n = 1'b1;
        tick();
        check_reset_state("reset_released");

        foreach (vecs[i]) run_op(vecs[i], $sformatf("vec%0d", i));

        for (int i = 0; i < 8; i++) begin
            ra = {$urandom(), $urandom()};
            rb = {$urandom(), $urandom()};
            rc = 1'($urandom() & 1);
`ifdef CHUNKED_ADDER_SUB_EN
            m  = model(ra, rb, rc, 1'(i & 1));
            run_op(mk(ra, rb, rc, 1'(i & 1), m.sum, m.cout, m.ovf, i % 3, 1'b0),
                   $sformatf("rand%0d", i));
`else
            m  = model(ra, rb, rc, 1'b0);
            run_op(mk(ra, rb, rc, 1'b0, m.sum, m.cout, m.ovf, i % 3, 1'b0),
                   $sformatf("rand%0d", i));
`endif
        end

        // Reset during the second RUN cycle (the only RUN cycle when NCHUNK is 1).
        wait_ready("rst_mid");
        drive_ops(64'h0123_4567_89AB_CDEF, 64'h0FED_CBA9_8765_4321, 1'b1, 1'b0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        if (NCHUNK > 1) tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_reset_state("rst_mid");
        seen = 1'b0;
        for (int i = 0; i < int'(NCHUNK) + 4; i++) begin
            if (out_valid) seen = 1'b1;
            tick();
        end
        check_bit("rst_mid no_out_valid", seen, 1'b0);
        run_op(mk(64'd5, 64'd10, 1'b0, 1'b0, 64'hF, 1'b0, 1'b0, 0, 1'b0), "post_reset");

        check_int("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
